// File: rtl/lc3_mio_devregs.sv
// LC-3 memory-mapped I/O device registers: keyboard FIFO (KBSR/KBDR),
// display handshake (DSR/DDR) and the MDR read-source multiplexer.
module lc3_mio_devregs #(
  parameter int KB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] MIO_DATA_IN,
  input  logic        LD_KBSR,
  input  logic        LD_DSR,
  input  logic        LD_DDR,
  input  logic        RD_KBDR,
  input  logic [1:0]  INMUX,
  input  logic [15:0] MEM_DOUT,
  output logic [15:0] MIO_DATA_OUT,
  input  logic [7:0]  KB_DATA,
  input  logic        KB_VALID,
  output logic        KB_READY,
  output logic [7:0]  DSP_DATA,
  output logic        DSP_VALID,
  input  logic        DSP_ACK,
  output logic        KB_INT,
  output logic        DSP_INT
);

  localparam int PW = (KB_DEPTH > 1) ? $clog2(KB_DEPTH) : 1;
  localparam logic [PW:0] KB_FULL = (PW+1)'(KB_DEPTH);

  typedef enum logic {IDLE, SEND} dsp_state_t;

  logic [7:0]    kb_mem [KB_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          kb_ie;
  logic          kb_ovf;
  logic          rd_kbdr_q;
  logic          nonempty;
  logic          kb_push;
  logic          kb_pop;
  logic [15:0]   kbsr_val;
  logic [15:0]   kbdr_val;

  dsp_state_t    state;
  dsp_state_t    state_next;
  logic [7:0]    ddr;
  logic          ddr_load;
  logic          dsp_ie;
  logic          dsp_ready;
  logic          ld_ddr_q;
  logic          ld_ddr_rise;
  logic [15:0]   dsr_val;

  logic          unused_data_bits;

  assign unused_data_bits = ^{MIO_DATA_IN[15], MIO_DATA_IN[13:8]};

  assign nonempty = (count != '0);
  assign KB_READY = (count != KB_FULL);
  assign kb_push  = KB_VALID & KB_READY;
  // The CPU holds RD_KBDR for the whole access, so the character is consumed
  // only once the access ends; the head stays stable while it is being read.
  assign kb_pop   = rd_kbdr_q & ~RD_KBDR & nonempty;

  always_ff @(posedge clk) begin
    if (kb_push) begin
      kb_mem[wr_ptr] <= KB_DATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_kbdr_q <= 1'b0;
    end else begin
      rd_kbdr_q <= RD_KBDR;
      if (kb_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (kb_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({kb_push, kb_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A status write always clears the overflow flag, even if a character is
  // dropped in that same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kb_ie  <= 1'b0;
      kb_ovf <= 1'b0;
    end else if (LD_KBSR) begin
      kb_ie  <= MIO_DATA_IN[14];
      kb_ovf <= 1'b0;
    end else if (KB_VALID && !KB_READY) begin
      kb_ovf <= 1'b1;
    end
  end

  assign kbsr_val = {nonempty, kb_ie, kb_ovf, 13'b0};
  assign kbdr_val = nonempty ? {8'h00, kb_mem[rd_ptr]} : 16'h0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsp_ie   <= 1'b0;
      ld_ddr_q <= 1'b0;
      ddr      <= 8'h00;
    end else begin
      ld_ddr_q <= LD_DDR;
      if (LD_DSR) begin
        dsp_ie <= MIO_DATA_IN[14];
      end
      if (ddr_load) begin
        ddr <= MIO_DATA_IN[7:0];
      end
    end
  end

  assign ld_ddr_rise = LD_DDR & ~ld_ddr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // New characters are accepted only when the display is idle; a store that
  // arrives mid-transfer is dropped rather than overwriting DDR.
  always_comb begin
    state_next = state;
    ddr_load   = 1'b0;
    case (state)
      IDLE: begin
        if (ld_ddr_rise) begin
          state_next = SEND;
          ddr_load   = 1'b1;
        end
      end
      SEND: begin
        if (DSP_ACK) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign dsp_ready = (state == IDLE);
  assign dsr_val   = {dsp_ready, dsp_ie, 14'b0};
  assign DSP_VALID = (state == SEND);
  assign DSP_DATA  = ddr;

  assign KB_INT  = nonempty & kb_ie;
  assign DSP_INT = dsp_ready & dsp_ie;

  always_comb begin
    MIO_DATA_OUT = MEM_DOUT;
    case (INMUX)
      2'b00:   MIO_DATA_OUT = kbsr_val;
      2'b01:   MIO_DATA_OUT = kbdr_val;
      2'b10:   MIO_DATA_OUT = dsr_val;
      default: MIO_DATA_OUT = MEM_DOUT;
    endcase
  end

endmodule

// File: tb/tb_lc3_mio_devregs.sv
// Self-checking bench for lc3_mio_devregs: queue scoreboards for keyboard
// characters and display characters plus a small register model.
module tb_lc3_mio_devregs;

  localparam int KB_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] MIO_DATA_IN;
  logic        LD_KBSR;
  logic        LD_DSR;
  logic        LD_DDR;
  logic        RD_KBDR;
  logic [1:0]  INMUX;
  logic [15:0] MEM_DOUT;
  logic [15:0] MIO_DATA_OUT;
  logic [7:0]  KB_DATA;
  logic        KB_VALID;
  logic        KB_READY;
  logic [7:0]  DSP_DATA;
  logic        DSP_VALID;
  logic        DSP_ACK;
  logic        KB_INT;
  logic        DSP_INT;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] kb_exp[$];
  logic [7:0] dsp_exp[$];
  bit         m_kb_ie;
  bit         m_kb_ovf;
  bit         m_dsp_ie;
  bit         m_dsp_busy;
  logic [7:0] m_ddr;

  lc3_mio_devregs #(.KB_DEPTH(KB_DEPTH)) dut (
    .clk(clk), .rst(rst), .MIO_DATA_IN(MIO_DATA_IN),
    .LD_KBSR(LD_KBSR), .LD_DSR(LD_DSR), .LD_DDR(LD_DDR),
    .RD_KBDR(RD_KBDR), .INMUX(INMUX), .MEM_DOUT(MEM_DOUT),
    .MIO_DATA_OUT(MIO_DATA_OUT), .KB_DATA(KB_DATA), .KB_VALID(KB_VALID),
    .KB_READY(KB_READY), .DSP_DATA(DSP_DATA), .DSP_VALID(DSP_VALID),
    .DSP_ACK(DSP_ACK), .KB_INT(KB_INT), .DSP_INT(DSP_INT)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_kbsr();
    return {(kb_exp.size() != 0), m_kb_ie, m_kb_ovf, 13'b0};
  endfunction

  function automatic logic [15:0] exp_kbdr();
    return (kb_exp.size() != 0) ? {8'h00, kb_exp[0]} : 16'h0000;
  endfunction

  function automatic logic [15:0] exp_dsr();
    return {~m_dsp_busy, m_dsp_ie, 14'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    kb_exp.delete();
    dsp_exp.delete();
    m_kb_ie    = 0;
    m_kb_ovf   = 0;
    m_dsp_ie   = 0;
    m_dsp_busy = 0;
    m_ddr      = 8'h00;
  endtask

  task automatic checkStatus(input string tag);
    INMUX = 2'b00;
    #1 checkOutput({tag, "_kbsr"}, MIO_DATA_OUT, exp_kbsr());
    INMUX = 2'b10;
    #1 checkOutput({tag, "_dsr"}, MIO_DATA_OUT, exp_dsr());
    checkOutput({tag, "_kb_int"}, KB_INT, (kb_exp.size() != 0) && m_kb_ie);
    checkOutput({tag, "_dsp_int"}, DSP_INT, !m_dsp_busy && m_dsp_ie);
    checkOutput({tag, "_kb_ready"}, KB_READY, kb_exp.size() != KB_DEPTH);
    checkOutput({tag, "_dsp_valid"}, DSP_VALID, m_dsp_busy);
    checkOutput({tag, "_dsp_data"}, DSP_DATA, m_ddr);
  endtask

  task automatic pushKey(input logic [7:0] c);
    KB_DATA  = c;
    KB_VALID = 1'b1;
    #1 checkOutput("push_kb_ready", KB_READY, kb_exp.size() != KB_DEPTH);
    if (kb_exp.size() != KB_DEPTH) kb_exp.push_back(c);
    else m_kb_ovf = 1;
    tick();
    KB_VALID = 1'b0;
  endtask

  task automatic readKbdr(input int hold);
    INMUX   = 2'b01;
    RD_KBDR = 1'b1;
    for (int i = 0; i < hold; i++) begin
      #1 checkOutput("kbdr_during_read", MIO_DATA_OUT, exp_kbdr());
      tick();
    end
    RD_KBDR = 1'b0;
    if (kb_exp.size() != 0) void'(kb_exp.pop_front());
    tick();
  endtask

  task automatic writeKbsr(input logic [15:0] data, input int cycles);
    MIO_DATA_IN = data;
    LD_KBSR     = 1'b1;
    repeat (cycles) tick();
    LD_KBSR  = 1'b0;
    m_kb_ie  = data[14];
    m_kb_ovf = 0;
  endtask

  task automatic writeDsr(input logic [15:0] data);
    MIO_DATA_IN = data;
    LD_DSR      = 1'b1;
    tick();
    LD_DSR   = 1'b0;
    m_dsp_ie = data[14];
  endtask

  task automatic writeDdr(input logic [15:0] data, input int cycles);
    MIO_DATA_IN = data;
    LD_DDR      = 1'b1;
    if (!m_dsp_busy) begin
      m_dsp_busy = 1;
      m_ddr      = data[7:0];
      dsp_exp.push_back(data[7:0]);
    end
    repeat (cycles) tick();
    LD_DDR = 1'b0;
    tick();
  endtask

  task automatic ackDisplay();
    logic [7:0] exp_c;
    int waited = 0;
    while (!DSP_VALID && waited < 10) begin
      tick();
      waited++;
    end
    checkOutput("dsp_valid_wait", DSP_VALID, 1'b1);
    exp_c = (dsp_exp.size() != 0) ? dsp_exp.pop_front() : 8'h00;
    checkOutput("dsp_data_at_ack", DSP_DATA, exp_c);
    DSP_ACK = 1'b1;
    tick();
    DSP_ACK    = 1'b0;
    m_dsp_busy = 0;
    #1 checkOutput("dsp_valid_after_ack", DSP_VALID, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    MIO_DATA_IN = '0; LD_KBSR = 0; LD_DSR = 0; LD_DDR = 0; RD_KBDR = 0;
    INMUX = 2'b00; MEM_DOUT = '0; KB_DATA = '0; KB_VALID = 0; DSP_ACK = 0;
    model_reset();

    #2;
    checkOutput("rst_kb_ready", KB_READY, 1'b1);
    checkOutput("rst_dsp_valid", DSP_VALID, 1'b0);
    checkOutput("rst_dsp_data", DSP_DATA, 16'h0000);
    checkOutput("rst_kb_int", KB_INT, 1'b0);
    checkOutput("rst_dsp_int", DSP_INT, 1'b0);
    INMUX = 2'b10;
    #1 checkOutput("rst_dsr", MIO_DATA_OUT, 16'h8000);
    INMUX = 2'b00;
    #1 checkOutput("rst_kbsr", MIO_DATA_OUT, 16'h0000);
    tick();
    tick();
    rst = 1'b0;

    INMUX = 2'b11; MEM_DOUT = 16'hBEEF;
    #1 checkOutput("mem_pass_a", MIO_DATA_OUT, 16'hBEEF);
    MEM_DOUT = 16'h1234;
    #1 checkOutput("mem_pass_b", MIO_DATA_OUT, 16'h1234);

    // Two characters, read with a held strobe
    pushKey(8'h41);
    pushKey(8'h42);
    checkStatus("two_chars");
    readKbdr(3);
    INMUX = 2'b01;
    #1 checkOutput("kbdr_second", MIO_DATA_OUT, 16'h0042);
    INMUX = 2'b00;
    #1 checkOutput("kbsr_one_left", MIO_DATA_OUT, 16'h8000);
    readKbdr(1);
    checkStatus("drained");
    readKbdr(2);
    checkStatus("pop_empty");

    // Overflow at depth 4
    for (int i = 0; i < 5; i++) pushKey(8'h30 + 8'(i));
    INMUX = 2'b00;
    #1 checkOutput("kbsr_ovf", MIO_DATA_OUT, 16'hA000);
    checkOutput("kb_ready_full", KB_READY, 1'b0);
    writeKbsr(16'h4000, 1);
    #1 checkOutput("kbsr_ie", MIO_DATA_OUT, 16'hC000);
    checkOutput("kb_int_on", KB_INT, 1'b1);
    for (int i = 0; i < 4; i++) readKbdr(1 + i % 2);
    checkStatus("ovf_drained");

    // Simultaneous push and pop with two characters queued
    pushKey(8'h50);
    pushKey(8'h51);
    INMUX   = 2'b01;
    RD_KBDR = 1'b1;
    #1 checkOutput("kbdr_before_swap", MIO_DATA_OUT, exp_kbdr());
    tick();
    RD_KBDR  = 1'b0;
    KB_VALID = 1'b1;
    KB_DATA  = 8'h52;
    kb_exp.push_back(8'h52);
    void'(kb_exp.pop_front());
    tick();
    KB_VALID = 1'b0;
    #1 checkOutput("kbdr_after_swap", MIO_DATA_OUT, 16'h0051);
    pushKey(8'h53);
    pushKey(8'h54);
    pushKey(8'h55);
    checkStatus("swap_full");
    for (int i = 0; i < 4; i++) readKbdr(1);
    writeKbsr(16'h0000, 2);
    checkStatus("kb_cleared");

    // Display transfer, ignored second store, ignored idle ack
    writeDdr(16'h0058, 3);
    checkStatus("dsp_send");
    tick();
    tick();
    checkOutput("dsp_still_valid", DSP_VALID, 1'b1);
    writeDdr(16'h0059, 2);
    checkOutput("dsp_data_held", DSP_DATA, 16'h0058);
    ackDisplay();
    checkStatus("dsp_done");
    DSP_ACK = 1'b1;
    tick();
    DSP_ACK = 1'b0;
    checkStatus("idle_ack");
    writeDsr(16'h4000);
    checkStatus("dsp_ie");
    writeDdr(16'h0065, 1);
    checkStatus("dsp_ie_send");
    ackDisplay();
    checkStatus("dsp_ie_done");

    // Reset in the middle of a transfer
    pushKey(8'h77);
    writeDdr(16'h005A, 1);
    checkOutput("pre_rst_valid", DSP_VALID, 1'b1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    checkOutput("mid_rst_dsp_valid", DSP_VALID, 1'b0);
    checkOutput("mid_rst_dsp_data", DSP_DATA, 16'h0000);
    checkOutput("mid_rst_kb_ready", KB_READY, 1'b1);
    tick();
    rst = 1'b0;
    INMUX = 2'b10;
    #1 checkOutput("post_rst_dsr", MIO_DATA_OUT, 16'h8000);
    checkStatus("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
